// File: rtl/score_digit_if.sv
// Frame-sampled score input and BCD digit outputs between the entity table,
// the digit unit and the score-sprite renderer.
interface score_digit_if #(parameter int SCORE_W = 8);
    logic               frame_clk;
    logic [SCORE_W-1:0] score;
    logic               res;
    logic [3:0]         ones, tens, hund;
    logic [3:0]         hi_ones, hi_tens, hi_hund;
    logic               digits_valid;
    logic               busy;
    logic               new_high;

    modport master (
        output frame_clk, score, res,
        input  ones, tens, hund, hi_ones, hi_tens, hi_hund,
               digits_valid, busy, new_high
    );

    modport slave (
        input  frame_clk, score, res,
        output ones, tens, hund, hi_ones, hi_tens, hi_hund,
               digits_valid, busy, new_high
    );
endinterface

// File: rtl/score_digit_unit.sv
// Once-per-frame binary-to-BCD (double dabble) conversion of the game score,
// with a session high score kept in both binary and BCD form.
module score_digit_unit #(
    parameter int SCORE_W = 8
) (
    input  logic         Clk,
    input  logic         Reset_n,
    score_digit_if.slave bus
);
    localparam int SR_W  = SCORE_W + 12;
    localparam int CNT_W = $clog2(SCORE_W) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         sync_q;
    logic               frame_edge;
    logic [SCORE_W-1:0] snap_bin_q, hi_bin_q;
    logic               snap_res_q;
    logic [SR_W-1:0]    sr_q, sr_adj;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         ones_q, tens_q, hund_q;
    logic [3:0]         hi_ones_q, hi_tens_q, hi_hund_q;
    logic               valid_q, busy_q, new_high_q;
    logic [3:0]         d_ones, d_tens, d_hund;

    assign frame_edge = sync_q[1] & ~sync_q[2];
    assign d_ones = sr_q[SCORE_W     +: 4];
    assign d_tens = sr_q[SCORE_W + 4 +: 4];
    assign d_hund = sr_q[SCORE_W + 8 +: 4];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_edge) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(SCORE_W - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Add-3 on every BCD nibble >= 5 before the shift; nibbles never exceed 9.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < 3; i++) begin
            if (sr_q[SCORE_W + 4*i +: 4] >= 4'd5)
                sr_adj[SCORE_W + 4*i +: 4] = sr_q[SCORE_W + 4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            snap_bin_q <= '0;
            snap_res_q <= 1'b0;
            hi_bin_q   <= '0;
            sr_q       <= '0;
            cnt_q      <= '0;
            ones_q     <= '0;
            tens_q     <= '0;
            hund_q     <= '0;
            hi_ones_q  <= '0;
            hi_tens_q  <= '0;
            hi_hund_q  <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            new_high_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[1:0], bus.frame_clk};
            new_high_q <= 1'b0;
            // Stays high through the new_high cycle so busy spans LOAD..DONE+1.
            busy_q     <= (state_d != IDLE) || (state_q == DONE);
            case (state_q)
                IDLE: if (frame_edge) begin
                    snap_bin_q <= bus.score;
                    snap_res_q <= bus.res;
                end
                LOAD: begin
                    sr_q  <= SR_W'(snap_bin_q);
                    cnt_q <= '0;
                end
                SHIFT: begin
                    sr_q  <= {sr_adj[SR_W-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: begin
                    valid_q <= 1'b1;
                    if (snap_res_q) begin
                        ones_q <= '0;
                        tens_q <= '0;
                        hund_q <= '0;
                    end else begin
                        ones_q <= d_ones;
                        tens_q <= d_tens;
                        hund_q <= d_hund;
                        if (snap_bin_q > hi_bin_q) begin
                            hi_bin_q   <= snap_bin_q;
                            hi_ones_q  <= d_ones;
                            hi_tens_q  <= d_tens;
                            hi_hund_q  <= d_hund;
                            new_high_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ones         = ones_q;
    assign bus.tens         = tens_q;
    assign bus.hund         = hund_q;
    assign bus.hi_ones      = hi_ones_q;
    assign bus.hi_tens      = hi_tens_q;
    assign bus.hi_hund      = hi_hund_q;
    assign bus.digits_valid = valid_q;
    assign bus.busy         = busy_q;
    assign bus.new_high     = new_high_q;
endmodule

// File: tb/tb_score_digit_unit.sv
// Self-checking bench: directed and random frames against a decimal model.
module tb_score_digit_unit;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    score_digit_if #(.SCORE_W(8)) bus ();
    score_digit_unit #(.SCORE_W(8)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

    int n_chk = 0, n_fail = 0;
    int m_last, m_hi;
    bit m_valid;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".ones"}, int'(bus.ones), m_last % 10);
        chk({tag, ".tens"}, int'(bus.tens), (m_last / 10) % 10);
        chk({tag, ".hund"}, int'(bus.hund), m_last / 100);
        chk({tag, ".hi_ones"}, int'(bus.hi_ones), m_hi % 10);
        chk({tag, ".hi_tens"}, int'(bus.hi_tens), (m_hi / 10) % 10);
        chk({tag, ".hi_hund"}, int'(bus.hi_hund), m_hi / 100);
        chk({tag, ".valid"}, int'(bus.digits_valid), int'(m_valid));
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        bus.frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        m_last = 0; m_hi = 0; m_valid = 1'b0;
        @(posedge Clk); #1;
        check_outputs("reset");
        chk("reset.busy", int'(bus.busy), 0);
        chk("reset.new_high", int'(bus.new_high), 0);
    endtask

    // One frame; optional second edge 5 cycles later with a different score.
    task automatic frame(input int s, input bit r, input bit dbl, input string tag);
        int busy_n = 0, nh_n = 0, nh_at = -1, out_at = -1;
        bit exp_nh;
        @(negedge Clk);
        bus.score = 8'(s);
        bus.res = r;
        bus.frame_clk = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge Clk); #1;
            if (k == 2) bus.frame_clk = 1'b0;
            if (dbl && k == 4) begin bus.frame_clk = 1'b1; bus.score = 8'(255 - s); bus.res = ~r; end
            if (dbl && k == 6) bus.frame_clk = 1'b0;
            if (bus.busy) busy_n++;
            if (bus.new_high) begin nh_n++; nh_at = k; end
            if (out_at < 0 && bus.digits_valid && k >= 1 && !bus.busy && k > 2) out_at = k;
        end
        exp_nh = !r && (s > m_hi);
        m_valid = 1'b1;
        m_last = r ? 0 : s;
        if (exp_nh) m_hi = s;
        check_outputs(tag);
        chk({tag, ".busy_cycles"}, busy_n, 11);
        chk({tag, ".new_high_cnt"}, nh_n, int'(exp_nh));
        if (exp_nh) chk({tag, ".new_high_at"}, nh_at, 12);
        chk({tag, ".busy_end"}, out_at, 13);
        if (dbl) begin
            busy_n = 0;
            repeat (16) begin @(posedge Clk); #1; if (bus.busy) busy_n++; end
            chk({tag, ".dropped_busy"}, busy_n, 0);
            check_outputs({tag, ".after_drop"});
        end
    endtask

    initial begin
        bus.frame_clk = 1'b0;
        bus.score = '0;
        bus.res = 1'b0;
        do_reset();

        begin
            int b = 0;
            repeat (20) begin @(posedge Clk); #1; if (bus.busy) b++; end
            chk("idle.busy", b, 0);
            check_outputs("idle");
        end

        frame(137, 1'b0, 1'b0, "s137");

        do_reset();
        for (int s = 0; s < 256; s++) frame(s, 1'b0, 1'b0, "sweep");

        do_reset();
        frame(42, 1'b0, 1'b0, "seq42a");
        frame(17, 1'b0, 1'b0, "seq17");
        frame(42, 1'b0, 1'b0, "seq42b");
        frame(99, 1'b1, 1'b0, "res99");
        frame(200, 1'b0, 1'b1, "double");

        do_reset();
        repeat (60) frame(int'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0), 1'b0, "rand");

        // Asynchronous reset landing in the middle of SHIFT.
        @(negedge Clk);
        bus.score = 8'd251; bus.res = 1'b0; bus.frame_clk = 1'b1;
        repeat (6) @(posedge Clk);
        bus.frame_clk = 1'b0;
        #3 Reset_n = 1'b0;
        #1;
        m_last = 0; m_hi = 0; m_valid = 1'b0;
        check_outputs("midreset");
        chk("midreset.busy", int'(bus.busy), 0);
        chk("midreset.new_high", int'(bus.new_high), 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        frame(77, 1'b0, 1'b0, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/score_digit_unit.md
# score_digit_unit

Converts the 8-bit game score produced by the entity table into three BCD digits for the score-sprite renderer, once per video frame. It also tracks a session high score. The block runs on the system clock and samples the entity table's frame_clk as a data input. It sits directly downstream of the entity table's `score`/`res` outputs and upstream of the digit-glyph lookup used by the score sprites.

## Interface
- SCORE_W, default 8: score width. Legal range is 1..9; the output is always 3 BCD digits (max 999).
- Clk  in  1  system clock; all state is clocked on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  frame tick from the VGA vsync, asynchronous to Clk. Passes through a 2-FF synchronizer followed by a rising-edge detect.
- score  in  SCORE_W  current score, binary.
- res  in  1  game-reset indicator, high while the entity table is in its restart state.
- ones, tens, hund  out  4 each  BCD digits of the last converted score.
- hi_ones, hi_tens, hi_hund  out  4 each  BCD digits of the high score.
- digits_valid  out  1  sticky; goes high after the first completed conversion.
- busy  out  1  high while a conversion is in progress.
- new_high  out  1  one-cycle pulse when the high score is updated.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE -> LOAD on a synchronized frame_clk rising edge (`sync2 & ~sync3`). The same edge captures `score` into snap_bin and `res` into snap_res.
  - LOAD -> SHIFT: shift register = {12'b0, snap_bin}; iteration counter = 0.
  - SHIFT: each cycle, add 3 to each of the three BCD nibbles that is >= 5, then shift the whole register left by 1 and increment the counter. The cycle with counter == SCORE_W-1 exits to DONE.
  - DONE -> IDLE: register the converted digits onto ones/tens/hund and set digits_valid.
- Edge handling:
  - A frame edge detected outside IDLE is dropped. No queueing; the next frame re-samples the score.
  - A frame edge in the DONE cycle is also dropped.
- High score:
  - hi_bin is SCORE_W bits, reset to 0.
  - In DONE, if snap_bin > hi_bin: hi_bin <= snap_bin, hi_* <= the new digits, and new_high pulses for exactly the cycle after DONE.
  - Equal values do not update hi_bin and do not pulse new_high.
  - res does not clear the high score; only Reset_n does.
- Restart handling: if snap_res = 1, ones/tens/hund are forced to 0 regardless of snap_bin, and the high-score compare is skipped.
- Arithmetic:
  - Nibble add-3 is a 4-bit add; no carry is possible because the input is <= 9.
  - With SCORE_W = 8, hund never exceeds 2.
- Reset mid-operation: Reset_n low returns the FSM to IDLE immediately and clears all registers, including the synchronizer flops.

## Timing
- Reset values: ones/tens/hund = 0, hi_* = 0, digits_valid = 0, busy = 0, new_high = 0, hi_bin = 0, FSM = IDLE, synchronizer flops = 0.
- Latency, counting the first Clk edge that samples frame_clk high as edge 0:
  - sync2 goes high at edge 1; the edge is detected in the following cycle.
  - Snapshot is taken and the FSM enters LOAD at edge 2.
  - FSM enters SHIFT at edge 3.
  - Shifts occur at edges 4..11, and the FSM enters DONE at edge 11. (General form: DONE at edge 3+SCORE_W.)
  - Outputs update and the FSM returns to IDLE at edge 12.
  - new_high is high between edges 12 and 13.
- busy is high from edge 2 through edge 12, i.e. during LOAD, SHIFT and DONE. Minimum frame_clk period is 14 Clk cycles.
- Outputs hold stable between DONE updates, so the renderer can sample them at any time.

## Test plan
- Reset with Reset_n low for 3 cycles, then high -> all outputs 0 and busy = 0; no activity without frame_clk edges.
- score = 8'd137, one frame_clk pulse -> at edge 12: hund = 1, tens = 3, ones = 7, digits_valid = 1. Also hi_* = 1/3/7 with a single new_high pulse, and busy is high for exactly 11 cycles.
- Sweep score = 0..255, one frame each -> every conversion matches the decimal value. hund = 2 for score = 255; new_high pulses only on strictly increasing values.
- Sequence score = 42, then 17, then 42 -> hi_* stays 0/4/2 and new_high pulses only on the first frame.
- res = 1 with score = 99 -> ones/tens/hund = 0, hi_* unchanged, no new_high.
- Second frame_clk edge arriving 5 cycles after the first -> it is ignored and the first result is unaffected. Reset_n asserted during SHIFT -> all outputs return to 0 asynchronously and busy = 0.
